draw_sequencer: RTL and testbench
=================================

# draw_sequencer

Control stage that sits between the frame timing and the line rasteriser / framebuffer pair. Once enabled, it waits for a frame strobe and optionally clears the framebuffer. It then steps a line index through every line of the shape, issuing one `draw_start` per line and waiting for `draw_done`. Throughout, it multiplexes the framebuffer address/write port between the clear sweep, the rasteriser and the display scan.

## Interface
Parameters:
- `XY_BITW`, 8, width of all x/y coordinates
- `LINE_CNT`, 12, number of lines per shape (≥1)
- `LINEW`, `$clog2(LINE_CNT)`, width of `line_id` (≥1)
- `FB_WIDTH`, 16, framebuffer width in pixels (≥1, < 2**XY_BITW)
- `FB_HEIGHT`, 16, framebuffer height in pixels (≥1, < 2**XY_BITW)

Ports:
- `clk` in 1: pixel clock; single clock domain
- `rst` in 1: synchronous, active-high reset
- `enable` in 1: run permission (PLL lock); low aborts synchronously
- `frame` in 1: one-cycle start-of-frame strobe
- `redraw` in 1: one-cycle request to redraw the shape
- `draw_done` in 1: rasteriser finished the current line (one-cycle pulse)
- `drawing` in 1: rasteriser emitting a valid pixel this cycle
- `dl_x`, `dl_y` in XY_BITW: rasteriser pixel coordinate
- `sx`, `sy` in XY_BITW: display scan coordinate
- `line_id` out LINEW: index of the line being drawn
- `draw_start` out 1: one-cycle start pulse to the rasteriser
- `fb_x`, `fb_y` out XY_BITW: framebuffer address
- `fb_we` out 1: framebuffer write enable
- `fb_clear` out 1: high when the write colour must be forced to 0
- `busy` out 1: high in CLEAR/INIT/DRAW
- `done` out 1: high in DONE

## Operation
- States: IDLE, CLEAR, INIT, DRAW, DONE.
- IDLE → CLEAR when `enable & frame`.
  - With the clear feature compiled out, IDLE → INIT instead.
- CLEAR → INIT:
  - Counters cx/cy sweep row-major (0,0)…(FB_WIDTH-1,FB_HEIGHT-1), one pixel per cycle.
  - FSM leaves CLEAR the cycle after (FB_WIDTH-1,FB_HEIGHT-1) is presented.
- INIT → DRAW unconditionally after one cycle.
- DRAW, on `draw_done`:
  - If `line_id==LINE_CNT-1`: go to DONE.
  - Otherwise: `line_id` increments and FSM returns to INIT.
- DONE holds. `redraw` in DONE → IDLE with `line_id` cleared; the restart waits for the next `frame`.
- `redraw` is ignored outside DONE. `frame` is ignored outside IDLE.
- `draw_done` is ignored outside DRAW. This includes a stale pulse arriving while in INIT.
- Any state with `enable==0` → IDLE next cycle; `line_id`←0; clear counters←0. `rst` has the same effect and takes priority.
- Outputs are decoded from the state register (glitch-free):
  - `draw_start` = (state==INIT).
  - `fb_we`: `drawing` in INIT/DRAW; 1 in CLEAR; 0 in IDLE/DONE.
  - `fb_x/fb_y`: cx/cy in CLEAR; `dl_x/dl_y` in INIT/DRAW; `sx/sy` in IDLE/DONE.
  - `fb_clear` = (state==CLEAR).

## Timing
- Reset values: state IDLE, `line_id`=0, `draw_start`=0, `fb_we`=0, `fb_clear`=0, `busy`=0, `done`=0, `fb_x/fb_y`=`sx/sy`.
- `frame` sampled at cycle N → CLEAR (or INIT) from N+1.
- Clear takes exactly FB_WIDTH·FB_HEIGHT cycles.
- Each line costs 1 INIT cycle plus the DRAW cycles up to and including `draw_done`.
- `line_id` changes in the same edge as the DRAW→INIT transition. It is therefore stable for the whole INIT+DRAW of a line.
- `done` rises one cycle after the final `draw_done`.

## Configuration
- `DRAW_SEQ_CLEAR_EN` defined:
  - CLEAR state and cx/cy counters are present.
  - `fb_clear` behaves as above.
- Not defined:
  - CLEAR is removed; IDLE goes straight to INIT.
  - `fb_clear` is tied 0.
  - No counter logic is synthesised.

## Structure
- Shared package `draw_pkg` holds:
  - `draw_state_t` enum {IDLE, CLEAR, INIT, DRAW, DONE}.
  - The framebuffer-port select encoding, shared with the top level and framebuffer.
- One sub-module, `fb_clear_scan`: row-major x/y counter with a `start`/`last` handshake.
  - Instantiated only under `DRAW_SEQ_CLEAR_EN`.

## Test plan
- Macro off, LINE_CNT=12, rasteriser model pulsing `draw_done` 3 cycles after each start, `enable`=1, one `frame`:
  - 12 single-cycle `draw_start` pulses, `line_id` 0..11 in order.
  - `done`=1 one cycle after the 12th `draw_done`.
- Macro on, 16×16, `frame` pulse:
  - 256 consecutive cycles of `fb_we`=1, `fb_clear`=1, coordinates (0,0)…(15,15).
  - `draw_start` on cycle 257.
- `enable` dropped while `line_id`=5 in DRAW:
  - Next cycle state IDLE, `line_id`=0, `fb_we`=0, `busy`=0.
  - A later `frame` restarts at line 0.
- In DONE, `sx`=7, `sy`=3 → `fb_x`=7, `fb_y`=3, `fb_we`=0.
  - `redraw` → IDLE; no `draw_start` until the next `frame`.
- `draw_done` injected during INIT, and `frame`/`redraw` injected during DRAW: all ignored; `line_id` unchanged.
- `rst` asserted mid-CLEAR: all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared types for the draw sequencer: FSM state encoding and framebuffer port select.
package draw_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    INIT  = 3'd2,
    DRAW  = 3'd3,
    DONE  = 3'd4
  } draw_state_t;

  // Which source owns the framebuffer address/write port.
  typedef enum logic [1:0] {
    FB_SEL_SCAN  = 2'd0,
    FB_SEL_CLEAR = 2'd1,
    FB_SEL_DRAW  = 2'd2
  } fb_sel_t;

  // Map a sequencer state onto the framebuffer port owner.
  function automatic fb_sel_t fb_sel_of(draw_state_t s);
    case (s)
      CLEAR:       return FB_SEL_CLEAR;
      INIT, DRAW:  return FB_SEL_DRAW;
      default:     return FB_SEL_SCAN;
    endcase
  endfunction

endpackage

// File: rtl/fb_clear_scan.sv
// Row-major x/y sweep over the framebuffer used by the clear pass.
// start returns the sweep to (0,0); step advances one pixel; last flags the final pixel.
module fb_clear_scan
  import draw_pkg::*;
#(
  parameter int unsigned XY_BITW   = 8,
  parameter int unsigned FB_WIDTH  = 16,
  parameter int unsigned FB_HEIGHT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               step,
  output logic [XY_BITW-1:0] cx,
  output logic [XY_BITW-1:0] cy,
  output logic               last
);

  localparam logic [XY_BITW-1:0] X_MAX = XY_BITW'(FB_WIDTH - 1);
  localparam logic [XY_BITW-1:0] Y_MAX = XY_BITW'(FB_HEIGHT - 1);

  logic [XY_BITW-1:0] cx_q, cx_d;
  logic [XY_BITW-1:0] cy_q, cy_d;

  // Next sweep position; wraps back to (0,0) after the last pixel.
  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (start) begin
      cx_d = '0;
      cy_d = '0;
    end else if (step) begin
      if (cx_q == X_MAX) begin
        cx_d = '0;
        cy_d = (cy_q == Y_MAX) ? '0 : cy_q + XY_BITW'(1);
      end else begin
        cx_d = cx_q + XY_BITW'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx   = cx_q;
  assign cy   = cy_q;
  assign last = (cx_q == X_MAX) && (cy_q == Y_MAX);

endmodule

// File: rtl/draw_sequencer.sv
// Frame-driven line sequencer: optional framebuffer clear, then one rasteriser
// start per line, with the framebuffer port muxed between clear, draw and scan.
// Optional feature: define DRAW_SEQ_CLEAR_EN to include the clear pass.
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int unsigned XY_BITW   = 8,
  parameter int unsigned LINE_CNT  = 12,
  parameter int unsigned LINEW     = (LINE_CNT > 1) ? $clog2(LINE_CNT) : 1,
  parameter int unsigned FB_WIDTH  = 16,
  parameter int unsigned FB_HEIGHT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               frame,
  input  logic               redraw,
  input  logic               draw_done,
  input  logic               drawing,
  input  logic [XY_BITW-1:0] dl_x,
  input  logic [XY_BITW-1:0] dl_y,
  input  logic [XY_BITW-1:0] sx,
  input  logic [XY_BITW-1:0] sy,
  output logic [LINEW-1:0]   line_id,
  output logic               draw_start,
  output logic [XY_BITW-1:0] fb_x,
  output logic [XY_BITW-1:0] fb_y,
  output logic               fb_we,
  output logic               fb_clear,
  output logic               busy,
  output logic               done
);

  localparam logic [LINEW-1:0] LINE_LAST = LINEW'(LINE_CNT - 1);

  draw_state_t      state_q, state_d;
  logic [LINEW-1:0] line_id_q, line_id_d;

`ifdef DRAW_SEQ_CLEAR_EN
  logic [XY_BITW-1:0] cx, cy;
  logic               clr_last;

  // Sweep restarts whenever we are not actively clearing, so CLEAR always begins at (0,0).
  fb_clear_scan #(
    .XY_BITW  (XY_BITW),
    .FB_WIDTH (FB_WIDTH),
    .FB_HEIGHT(FB_HEIGHT)
  ) u_clear_scan (
    .clk  (clk),
    .rst  (rst),
    .start((state_q != CLEAR) || !enable),
    .step (state_q == CLEAR),
    .cx   (cx),
    .cy   (cy),
    .last (clr_last)
  );
`endif

  // Next-state and line index; loss of enable overrides everything.
  always_comb begin
    state_d   = state_q;
    line_id_d = line_id_q;
    case (state_q)
      IDLE: begin
        if (frame) begin
`ifdef DRAW_SEQ_CLEAR_EN
          state_d = CLEAR;
`else
          state_d = INIT;
`endif
        end
      end
      CLEAR: begin
`ifdef DRAW_SEQ_CLEAR_EN
        if (clr_last) state_d = INIT;
`else
        state_d = IDLE;
`endif
      end
      INIT: state_d = DRAW;
      DRAW: begin
        if (draw_done) begin
          if (line_id_q == LINE_LAST) begin
            state_d = DONE;
          end else begin
            state_d   = INIT;
            line_id_d = line_id_q + LINEW'(1);
          end
        end
      end
      DONE: begin
        if (redraw) begin
          state_d   = IDLE;
          line_id_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        line_id_d = '0;
      end
    endcase
    if (!enable) begin
      state_d   = IDLE;
      line_id_d = '0;
    end
  end

  // State and line index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      line_id_q <= '0;
    end else begin
      state_q   <= state_d;
      line_id_q <= line_id_d;
    end
  end

  // Outputs decoded from the state register; framebuffer port muxed by owner.
  always_comb begin
    fb_x     = sx;
    fb_y     = sy;
    fb_we    = 1'b0;
    fb_clear = 1'b0;
    case (fb_sel_of(state_q))
      FB_SEL_CLEAR: begin
`ifdef DRAW_SEQ_CLEAR_EN
        fb_x     = cx;
        fb_y     = cy;
        fb_we    = 1'b1;
        fb_clear = 1'b1;
`endif
      end
      FB_SEL_DRAW: begin
        fb_x  = dl_x;
        fb_y  = dl_y;
        fb_we = drawing;
      end
      default: ;
    endcase
    draw_start = (state_q == INIT);
    busy       = (state_q == CLEAR) || (state_q == INIT) || (state_q == DRAW);
    done       = (state_q == DONE);
  end

  assign line_id = line_id_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer with a line-id scoreboard and a rasteriser model.
// Expectations follow DRAW_SEQ_CLEAR_EN when the bench is built with it.
module tb_draw_sequencer;

  localparam int unsigned XY_BITW   = 8;
  localparam int unsigned LINE_CNT  = 12;
  localparam int unsigned LINEW     = 4;
  localparam int unsigned FB_WIDTH  = 16;
  localparam int unsigned FB_HEIGHT = 16;

  logic               clk = 1'b0;
  logic               rst, enable, frame, redraw, draw_done, drawing;
  logic [XY_BITW-1:0] dl_x, dl_y, sx, sy;
  logic [LINEW-1:0]   line_id;
  logic               draw_start, fb_we, fb_clear, busy, done;
  logic [XY_BITW-1:0] fb_x, fb_y;

  draw_sequencer #(
    .XY_BITW  (XY_BITW),
    .LINE_CNT (LINE_CNT),
    .LINEW    (LINEW),
    .FB_WIDTH (FB_WIDTH),
    .FB_HEIGHT(FB_HEIGHT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame(frame), .redraw(redraw),
    .draw_done(draw_done), .drawing(drawing), .dl_x(dl_x), .dl_y(dl_y),
    .sx(sx), .sy(sy), .line_id(line_id), .draw_start(draw_start),
    .fb_x(fb_x), .fb_y(fb_y), .fb_we(fb_we), .fb_clear(fb_clear),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_q[$];
  int   pulses = 0;
  int   clr_idx = 0;
  int   rast_cnt = 0;
  bit   rast_auto = 1'b1;
  logic prev_start = 1'b0;
  logic prev_done = 1'b0;
  logic last_dd = 1'b0;
  logic saw_start = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle: sample at negedge, score outputs, then drive next inputs.
  task automatic step();
    int e;
    @(negedge clk);
    last_dd   = draw_done;
    saw_start = 1'b0;
    if (draw_start) begin
      saw_start = 1'b1;
      pulses++;
      check("start_single", prev_start, 0);
      if (exp_q.size() == 0) begin
        check("start_expected", draw_start, 0);
      end else begin
        e = exp_q.pop_front();
        check("line_id", line_id, e);
`ifdef DRAW_SEQ_CLEAR_EN
        if (e == 0) check("clear_len", clr_idx, FB_WIDTH * FB_HEIGHT);
`endif
      end
    end
    if (fb_clear) begin
      check("clr_we", fb_we, 1);
      check("clr_x", fb_x, clr_idx % FB_WIDTH);
      check("clr_y", fb_y, clr_idx / FB_WIDTH);
      clr_idx++;
    end else if (busy) begin
      check("draw_we", fb_we, drawing);
      check("draw_x", fb_x, dl_x);
      check("draw_y", fb_y, dl_y);
    end else begin
      check("scan_we", fb_we, 0);
      check("scan_x", fb_x, sx);
      check("scan_y", fb_y, sy);
    end
`ifndef DRAW_SEQ_CLEAR_EN
    check("clear_tied", fb_clear, 0);
`endif
    if (done && !prev_done) begin
      check("done_after_dd", last_dd, 1);
      check("pulses", pulses, LINE_CNT);
      check("done_line", line_id, LINE_CNT - 1);
    end
    prev_start = draw_start;
    prev_done  = done;
    frame      = 1'b0;
    redraw     = 1'b0;
    draw_done  = 1'b0;
    if (rast_cnt > 0) begin
      rast_cnt--;
      if (rast_cnt == 0) draw_done = rast_auto;
    end
    if (draw_start && rast_auto) rast_cnt = 3;
    drawing = 1'($urandom_range(0, 1));
    dl_x    = 8'($urandom_range(0, 255));
    dl_y    = 8'($urandom_range(0, 255));
  endtask

  // Frame strobe: queue the expected line sequence and check the first cycle.
  task automatic do_frame();
    for (int i = 0; i < int'(LINE_CNT); i++) exp_q.push_back(i);
    pulses  = 0;
    clr_idx = 0;
    frame   = 1'b1;
    step();
    check("frame_busy", busy, 1);
`ifdef DRAW_SEQ_CLEAR_EN
    check("frame_clear", fb_clear, 1);
`else
    check("frame_start", draw_start, 1);
`endif
  endtask

  task automatic run_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    check("done_timeout", done, 1);
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (!saw_start && n < budget) begin
      step();
      n++;
    end
    check("start_timeout", saw_start, 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_start"}, draw_start, 0);
    check({tag, "_we"}, fb_we, 0);
    check({tag, "_fbclr"}, fb_clear, 0);
    check({tag, "_line"}, line_id, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; enable = 1'b1; frame = 1'b1; redraw = 1'b0;
    draw_done = 1'b1; drawing = 1'b1; dl_x = 8'd1; dl_y = 8'd2;
    sx = 8'd5; sy = 8'd9;

    step();
    step();
    check_reset_state("rst");
    check("rst_fb_x", fb_x, 5);
    check("rst_fb_y", fb_y, 9);
    rst = 1'b0;
    step();
    check("idle_wait", busy, 0);

    // Full shape with the 3-cycle rasteriser model.
    do_frame();
    run_done(600);
    check("done_busy", busy, 0);

    // DONE shows the scan coordinates and never writes.
    sx = 8'd7; sy = 8'd3;
    step();
    check("done_fb_x", fb_x, 7);
    check("done_fb_y", fb_y, 3);
    check("done_we", fb_we, 0);
    frame = 1'b1;
    step();
    step();
    check("done_hold", done, 1);

    // redraw returns to IDLE and waits for a frame.
    redraw = 1'b1;
    step();
    check("redraw_done", done, 0);
    check("redraw_busy", busy, 0);
    check("redraw_line", line_id, 0);
    repeat (5) step();
    check("redraw_wait", busy, 0);

    // Stale draw_done in INIT, frame/redraw in DRAW: all ignored.
    rast_auto = 1'b0;
    do_frame();
    wait_start(600);
    draw_done = 1'b1;
    step();
    check("stale_busy", busy, 1);
    check("stale_start", draw_start, 0);
    check("stale_line", line_id, 0);
    frame = 1'b1; redraw = 1'b1;
    step();
    check("inj_busy", busy, 1);
    check("inj_start", draw_start, 0);
    check("inj_line", line_id, 0);
    check("inj_done", done, 0);
    step();
    check("inj_hold", draw_start, 0);
    draw_done = 1'b1;
    step();
    check("manual_next", draw_start, 1);
    check("manual_line", line_id, 1);
    rast_auto = 1'b1;
    rast_cnt  = 3;

    // Drop enable while line 5 is in DRAW.
    n = 0;
    while (!(saw_start && line_id == 4'd5) && n < 100) begin
      step();
      n++;
    end
    check("line5_timeout", line_id, 5);
    step();
    check("line5_draw", busy, 1);
    enable = 1'b0;
    step();
    check_reset_state("en_off");
    exp_q.delete();
    rast_cnt = 0;
    step();
    check("en_off_hold", busy, 0);
    enable = 1'b1;
    step();
    check("en_on_idle", busy, 0);
    do_frame();
    run_done(600);

    // Synchronous reset in the middle of a run.
    redraw = 1'b1;
    step();
    do_frame();
    repeat (10) step();
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("mid_rst");
    check("mid_rst_fb_x", fb_x, 7);
    check("mid_rst_fb_y", fb_y, 3);
    exp_q.delete();
    rast_cnt = 0;
    step();

    // Clean run after reset; scoreboard must drain completely.
    do_frame();
    run_done(600);
    check("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
